// File: rtl/bullet_pool_pkg.sv
// Shared game constants and coordinate types used by the bullet layer.
package bullet_pool_pkg;
  localparam int SCREEN_WRAP = 512;
  localparam int COORD_W     = 19;
  localparam int BULLET_W    = 4;
  localparam int BULLET_H    = 8;
  localparam int WRAP_W      = $clog2(SCREEN_WRAP);
  localparam int SPAWN_DX    = 13;
  localparam int SPAWN_DY    = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [WRAP_W-1:0]  wrap_t;

  // Index width that stays legal for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bullet_pool_if.sv
// Game-side signal bundle for the bullet pool: controls, raster position, kill request, outputs.
interface bullet_pool_if
  import bullet_pool_pkg::*;
#(
  parameter int NUM_SLOTS = 4
);
  localparam int KW = idx_w(NUM_SLOTS);

  logic                 start;
  logic                 fire_n;
  coord_t               ship_x;
  coord_t               ship_y;
  coord_t               x;
  coord_t               y;
  logic                 kill_valid;
  logic [KW-1:0]        kill_slot;
  logic [NUM_SLOTS-1:0] active;
  logic [23:0]          rgb;

  modport master (
    output start, fire_n, ship_x, ship_y, x, y, kill_valid, kill_slot,
    input  active, rgb
  );

  modport slave (
    input  start, fire_n, ship_x, ship_y, x, y, kill_valid, kill_slot,
    output active, rgb
  );
endinterface

// File: rtl/bullet_pool_btn_edge.sv
// Two-flop synchronizer for an active-low button plus a falling-edge detector.
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_fall
);
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // All flops rest at the released level so reset itself never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_fall = r_prev & ~r_sync2;
endmodule

// File: rtl/bullet_pool.sv
// Fixed pool of upward-moving bullets: spawn on fire, move on ticks, kill on request, raster overlay.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          TICK_DIV  = 100000,
  parameter int          SPEED     = 2,
  parameter int          COOLDOWN  = 8,
  parameter logic [23:0] COLOR     = 24'hFFFF00
) (
  input  logic         clock,
  input  logic         reset,
  bullet_pool_if.slave bus
);
  localparam int KW = idx_w(NUM_SLOTS);
  localparam int TW = idx_w(TICK_DIV);
  localparam int CW = idx_w(COOLDOWN + 1);

  logic [TW-1:0]        r_tick_cnt;
  logic [CW-1:0]        r_cool;
  logic                 r_active [NUM_SLOTS];
  wrap_t                r_bx     [NUM_SLOTS];
  coord_t               r_by     [NUM_SLOTS];

  logic                 w_fall;
  logic                 w_tick;
  logic                 w_free;
  logic                 w_spawn;
  logic [KW-1:0]        w_target;
  logic [NUM_SLOTS-1:0] w_cover;
  logic [NUM_SLOTS-1:0] w_active;
  wrap_t                w_spawn_bx;
  coord_t               w_spawn_by;

  btn_edge u_fire (
    .clock   (clock),
    .reset   (reset),
    .i_btn_n (bus.fire_n),
    .o_fall  (w_fall)
  );

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Target is chosen from registered occupancy, so a slot killed this cycle is not reused yet.
  always_comb begin
    w_free   = 1'b0;
    w_target = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_active[i]) begin
        w_free   = 1'b1;
        w_target = KW'(i);
      end
    end
  end

  assign w_spawn    = w_fall & bus.start & (r_cool == '0) & w_free;
  assign w_spawn_bx = wrap_t'(bus.ship_x + coord_t'(SPAWN_DX));
  assign w_spawn_by = bus.ship_y - coord_t'(SPAWN_DY);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      r_cool <= '0;
    else if (!bus.start)            r_cool <= '0;
    else if (w_spawn)               r_cool <= CW'(COOLDOWN);
    else if (w_tick && r_cool != 0) r_cool <= r_cool - 1'b1;
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      wrap_t  w_dx;
      coord_t w_dy;

      assign w_dx          = wrap_t'(bus.x - coord_t'(r_bx[gi]));
      assign w_dy          = bus.y - r_by[gi];
      assign w_cover[gi]   = r_active[gi] & (w_dx < wrap_t'(BULLET_W)) & (w_dy < coord_t'(BULLET_H));
      assign w_active[gi]  = r_active[gi];

      // Kill beats movement; a spawn can only land in a slot that was already empty.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_active[gi] <= 1'b0;
          r_bx[gi]     <= '0;
          r_by[gi]     <= '0;
        end else if (!bus.start) begin
          r_active[gi] <= 1'b0;
        end else if (r_active[gi] && bus.kill_valid && bus.kill_slot == KW'(gi)) begin
          r_active[gi] <= 1'b0;
        end else if (r_active[gi] && w_tick) begin
          if (r_by[gi] >= coord_t'(SPEED)) r_by[gi] <= r_by[gi] - coord_t'(SPEED);
          else                             r_active[gi] <= 1'b0;
        end else if (w_spawn && w_target == KW'(gi)) begin
          r_active[gi] <= 1'b1;
          r_bx[gi]     <= w_spawn_bx;
          r_by[gi]     <= w_spawn_by;
        end
      end
    end
  endgenerate

  assign bus.active = w_active;
  assign bus.rgb    = (bus.start && (|w_cover)) ? COLOR : 24'h000000;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with TICK_DIV=4, COOLDOWN=2, SPEED=2.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  localparam logic [23:0] YEL = 24'hFFFF00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bullet_pool_if #(.NUM_SLOTS(4)) bus ();

  bullet_pool #(
    .NUM_SLOTS (4),
    .TICK_DIV  (4),
    .SPEED     (2),
    .COOLDOWN  (2),
    .COLOR     (YEL)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Consumes 1 time unit; at most four calls fit between a negedge and the next posedge.
  task automatic pix(input string tag, input int px, input int py, input logic [23:0] exp);
    bus.x = coord_t'(px);
    bus.y = coord_t'(py);
    #1;
    check(tag, {8'h0, bus.rgb}, {8'h0, exp});
  endtask

  // One-cycle button pulse; returns at the negedge following the spawn edge.
  task automatic press();
    bus.fire_n = 1'b0;
    @(negedge clk);
    bus.fire_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.fire_n     = 1'b1;
    bus.ship_x     = coord_t'(320);
    bus.ship_y     = coord_t'(400);
    bus.x          = '0;
    bus.y          = '0;
    bus.kill_valid = 1'b0;
    bus.kill_slot  = '0;

    cyc(3);
    check("reset_active", {28'h0, bus.active}, 32'h0);
    check("reset_rgb", {8'h0, bus.rgb}, 32'h0);
    rst = 1'b0;
    bus.start = 1'b1;
    cyc(3);

    // First spawn and its three-edge latency
    bus.fire_n = 1'b0;
    cyc(1);
    bus.fire_n = 1'b1;
    cyc(1);
    check("latency_edge2", {28'h0, bus.active}, 32'h0);
    cyc(1);
    check("spawn_slot0", {28'h0, bus.active}, 32'h1);
    pix("pix_333_392", 333, 392, YEL);
    pix("pix_336_399", 336, 399, YEL);
    pix("pix_337_392", 337, 392, 24'h0);
    pix("pix_333_400", 333, 400, 24'h0);

    // 20 edges contain exactly 5 ticks: by 392 -> 382
    cyc(20);
    pix("move_333_382", 333, 382, YEL);
    pix("move_336_389", 336, 389, YEL);
    pix("move_333_390", 333, 390, 24'h0);
    pix("move_337_382", 337, 382, 24'h0);

    // Cooldown: second press lands within one tick of the first spawn
    press();
    check("spawn_slot1", {28'h0, bus.active}, 32'h3);
    press();
    check("cooldown_drop", {28'h0, bus.active}, 32'h3);
    cyc(8);
    press();
    check("cooldown_release", {28'h0, bus.active}, 32'h7);

    // Fill the pool, then a fifth press is dropped
    cyc(8);
    press();
    check("fill_slot3", {28'h0, bus.active}, 32'hF);
    cyc(8);
    press();
    check("full_drop", {28'h0, bus.active}, 32'hF);

    // Kill and fire on the same edge: slot 2 freed, spawn dropped
    bus.fire_n = 1'b0;
    cyc(1);
    bus.fire_n = 1'b1;
    cyc(1);
    bus.kill_valid = 1'b1;
    bus.kill_slot  = 2'd2;
    cyc(1);
    bus.kill_valid = 1'b0;
    check("kill_fire_same", {28'h0, bus.active}, 32'hB);
    // Drops above must not have started a cooldown
    press();
    check("slot2_reuse", {28'h0, bus.active}, 32'hF);

    bus.kill_valid = 1'b1;
    bus.kill_slot  = 2'd0;
    cyc(1);
    bus.kill_valid = 1'b0;
    check("kill_slot0", {28'h0, bus.active}, 32'hE);

    // Horizontal wrap: (500 + 13) & 511 = 1
    cyc(8);
    bus.ship_x = coord_t'(500);
    press();
    check("wrap_spawn", {28'h0, bus.active}, 32'hF);
    pix("wrap_x1", 1, 392, YEL);
    pix("wrap_x4", 4, 395, YEL);
    pix("wrap_x0", 0, 392, 24'h0);
    pix("wrap_x5", 5, 392, 24'h0);

    // Kill aimed at an empty slot must not block a spawn into it
    bus.kill_valid = 1'b1;
    bus.kill_slot  = 2'd3;
    cyc(1);
    bus.kill_valid = 1'b0;
    check("kill_slot3", {28'h0, bus.active}, 32'h7);
    cyc(8);
    bus.fire_n = 1'b0;
    cyc(1);
    bus.fire_n = 1'b1;
    cyc(1);
    bus.kill_valid = 1'b1;
    cyc(1);
    bus.kill_valid = 1'b0;
    check("kill_inactive_spawn", {28'h0, bus.active}, 32'hF);

    // start low blanks immediately and clears on the next edge
    bus.start = 1'b0;
    pix("start_low_rgb", 1, 392, 24'h0);
    check("start_low_comb", {28'h0, bus.active}, 32'hF);
    cyc(1);
    check("start_low_clear", {28'h0, bus.active}, 32'h0);
    cyc(2);
    check("start_low_hold", {28'h0, bus.active}, 32'h0);

    // by = 1 expires on the first tick
    bus.start  = 1'b1;
    bus.ship_x = coord_t'(320);
    bus.ship_y = coord_t'(9);
    cyc(2);
    press();
    check("by1_spawn", {28'h0, bus.active}, 32'h1);
    pix("by1_pix_top", 333, 1, YEL);
    pix("by1_pix_bot", 333, 8, YEL);
    pix("by1_pix_out", 333, 9, 24'h0);
    cyc(4);
    check("by1_expire", {28'h0, bus.active}, 32'h0);

    // by = 2 moves to 0, then expires on the second tick
    cyc(8);
    bus.ship_y = coord_t'(10);
    press();
    check("by2_spawn", {28'h0, bus.active}, 32'h1);
    cyc(4);
    check("by2_tick1", {28'h0, bus.active}, 32'h1);
    pix("by2_pix0", 333, 0, YEL);
    cyc(4);
    check("by2_tick2", {28'h0, bus.active}, 32'h0);

    // Asynchronous reset mid-cycle, then no spawn without a fresh press
    cyc(8);
    press();
    check("pre_reset_spawn", {28'h0, bus.active}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {28'h0, bus.active}, 32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(6);
    check("post_reset_idle", {28'h0, bus.active}, 32'h0);
    pix("post_reset_rgb", 333, 394, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bullet_pool.md
BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter NUM_SLOTS, default 4: number of simultaneous bullets.
REQ-002 Parameter TICK_DIV, default 100000: clocks per movement tick.
REQ-003 Parameter SPEED, default 2: pixels moved upward per tick.
REQ-004 Parameter COOLDOWN, default 8: ticks after a spawn during which fire is ignored.
REQ-005 Parameter COLOR, default 24'hFFFF00: bullet pixel colour.
REQ-006 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: game running; low clears and blanks all bullets.
REQ-009 Port fire_n, input, 1: fire button, active-low, asynchronous to clock.
REQ-010 Port ship_x / ship_y, input, 19 each: current ship top-left position.
REQ-011 Port x / y, input, 19 each: current raster pixel.
REQ-012 Port kill_valid, input, 1: collision logic requests slot removal.
REQ-013 Port kill_slot, input, clog2(NUM_SLOTS): slot to remove.
REQ-014 Port active, output, NUM_SLOTS: per-slot occupied flag.
REQ-015 Port rgb, output, 24: bullet layer pixel; 24'h000000 when transparent.

Function
REQ-016 fire_n SHALL pass through a 2-flop synchronizer; a fire event is a registered high-to-low transition of the synchronized signal.
REQ-017 A fire event SHALL set the target slot active on the 3rd rising clock edge after fire_n falls (setup met).
REQ-018 Spawn target SHALL be the lowest-index slot that was inactive at the start of the cycle; a slot freed by a kill in the same cycle SHALL NOT be reused that cycle.
REQ-019 Spawn position SHALL be bx = (ship_x + 13) & 511 and by = ship_y - 8, both sampled on the spawn cycle.
REQ-020 A fire event with no free slot, during cooldown, or while start is low SHALL be dropped; dropped events SHALL NOT start a cooldown.
REQ-021 A successful spawn SHALL load the cooldown counter with COOLDOWN; the counter SHALL decrement by one per tick, and fire SHALL be accepted only when it is 0.
REQ-022 The tick counter SHALL count 0..TICK_DIV-1 and SHALL assert a tick for one clock on wrap.
REQ-023 On a tick, each active slot with by >= SPEED SHALL set by = by - SPEED; each active slot with by < SPEED SHALL go inactive.
REQ-024 kill_valid SHALL clear active[kill_slot] on the next edge; a kill to an inactive slot, or to an out-of-range index, SHALL have no effect.
REQ-025 Precedence within one cycle SHALL be kill, then tick expiry/move, then spawn; a slot spawned this cycle SHALL NOT move on the same edge.
REQ-026 start low SHALL clear all slots and the cooldown counter on the next edge, and SHALL keep them cleared.
REQ-027 Slot i covers pixel (x,y) when active[i] and ((x - bx_i) & 511) < 4 and (y - by_i), as 19-bit unsigned, < 8.
REQ-028 rgb SHALL be combinational: COLOR when start and any slot covers (x,y), otherwise 24'h000000.

Reset
REQ-029 reset SHALL immediately clear active, all bx/by, the tick counter, the cooldown counter, the synchronizer flops (to 1, released) and the edge register.
REQ-030 After reset deassertion, no spawn SHALL occur until a fresh fire_n falling edge is observed.

Structure
REQ-031 Shared game package SHALL hold SCREEN_WRAP=512, the coordinate width 19, and bullet dimensions BULLET_W=4 and BULLET_H=8.
REQ-032 The synchronizer plus edge detector SHALL be the sub-module btn_edge; slot state SHALL be flat register arrays inside bullet_pool.

Verification (TICK_DIV=4, COOLDOWN=2)
REQ-033 Reset, start=1, ship=(320,400), fire_n pulse low -> slot 0 active 3 clocks later at bx=333, by=392; rgb=FFFF00 at (333,392) and (336,399); 0 at (337,392).
REQ-034 Slot 0 spawned at by=392 -> after 5 ticks by=382; spawned at by=1 -> cleared on the first tick.
REQ-035 Five fire events spaced beyond cooldown with no kills -> slots 0..3 fill; 5th dropped; active=4'b1111.
REQ-036 Second press within cooldown -> ignored; press after 2 ticks -> slot 1 spawns.
REQ-037 All slots full, kill_slot=2 and fire event in the same cycle -> slot 2 cleared, spawn dropped; next press -> slot 2 reused.
REQ-038 ship_x=500 -> bx=1; rgb hits at x=1..4; start dropped mid-flight -> active=0 next edge, rgb=0.
